picovid_wbuf: RTL and testbench

Posted-write buffer between the 68000 bus and the Pico poll/readout stage. It decodes CPU writes to the video window and completes each bus cycle with DTACK as soon as the write is queued. Address, data and byte lanes go into a small FIFO. The head entry is presented to the downstream poll stage through a valid/ack handshake, so the CPU stalls only while the FIFO is full.

---
 rtl/picovid_pkg.sv | 39 +++
 rtl/picovid_wbuf_fifo.sv | 80 ++++++++
 rtl/picovid_wbuf.sv | 144 ++++++++++++++
 tb/tb_picovid_wbuf.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/picovid_pkg.sv
// Shared types and constants for the picovid posted-write buffer.
package picovid_pkg;

    localparam logic [3:0]  ADDR_HI_DEFAULT = 4'hD;

    localparam int unsigned ADDR_W   = 24;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned BE_W     = 2;
    localparam int unsigned ENTRY_W  = ADDR_W + DATA_W + BE_W;

    localparam int unsigned BE_LSB   = 0;
    localparam int unsigned DATA_LSB = BE_LSB + BE_W;
    localparam int unsigned ADDR_LSB = DATA_LSB + DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_ACK   = 2'd2,
        ST_DONE  = 2'd3
    } wbuf_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   be;
    } wbuf_entry_t;

    // Build a queue entry from the word address, data and byte enables.
    function automatic wbuf_entry_t pack_entry(input logic [23:1]       a,
                                               input logic [DATA_W-1:0] d,
                                               input logic [BE_W-1:0]   be);
        wbuf_entry_t e;
        e.addr = {a, 1'b0};
        e.data = d;
        e.be   = be;
        return e;
    endfunction

endpackage

// File: rtl/picovid_wbuf_fifo.sv
// Circular-buffer FIFO holding posted writes; head is read combinationally.
module picovid_wbuf_fifo
    import picovid_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = ENTRY_W
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   fill_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FILL_W = PTR_W + 1;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              push_ok_c;
    logic              pop_ok_c;

    assign empty_o   = (fill_q == '0);
    assign full_o    = (fill_q == FILL_W'(DEPTH));
    // A pop on an empty FIFO is dropped; a push into a full FIFO only lands alongside a pop.
    assign pop_ok_c  = pop_i & ~empty_o;
    assign push_ok_c = push_i & (~full_o | pop_ok_c);

    // Next pointer and occupancy values.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        fill_d = fill_q;
        if (push_ok_c) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (pop_ok_c) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        case ({push_ok_c, pop_ok_c})
            2'b10:   fill_d = fill_q + FILL_W'(1);
            2'b01:   fill_d = fill_q - FILL_W'(1);
            default: fill_d = fill_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wptr_q <= '0;
            rptr_q <= '0;
            fill_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            fill_q <= fill_d;
        end
    end

    // Entry storage; cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok_c) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign fill_o  = fill_q;

endmodule

// File: rtl/picovid_wbuf.sv
// Posted-write buffer: decodes 68k writes to the video window, queues them
// and acks the bus once queued. Optional feature macro:
// PICOVID_WBUF_BYTELANE_EN (qualify LDS too and capture byte enables).
module picovid_wbuf
    import picovid_pkg::*;
#(
    parameter logic [3:0]  ADDR_HI = ADDR_HI_DEFAULT,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   AS,
    input  logic                   UDS,
    input  logic                   LDS,
    input  logic                   RW,
    input  logic [23:1]            A,
    input  logic [15:0]            D,
    output logic                   DTACK,
    output logic                   out_valid,
    output logic [23:0]            out_addr,
    output logic [15:0]            out_data,
    output logic [1:0]             out_be,
    input  logic                   out_ack,
    output logic [$clog2(DEPTH):0] fill
);

    wbuf_state_t          state_q;
    logic                 as_q, uds_q, lds_q, rw_q;
    logic                 dtack_q;
    logic                 ds_hit_c;
    logic [BE_W-1:0]      be_c;
    logic                 hit_c;
    logic                 space_c;
    logic                 push_c;
    logic                 full_w, empty_w;
    logic [ENTRY_W-1:0]   head_w;
    wbuf_entry_t          wentry_c;

    // Single-register sync of the bus strobes; the FSM only looks at these.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            as_q  <= 1'b1;
            uds_q <= 1'b1;
            lds_q <= 1'b1;
            rw_q  <= 1'b1;
        end else begin
            as_q  <= AS;
            uds_q <= UDS;
            lds_q <= LDS;
            rw_q  <= RW;
        end
    end

`ifdef PICOVID_WBUF_BYTELANE_EN
    assign ds_hit_c = ~uds_q | ~lds_q;
    assign be_c     = {~uds_q, ~lds_q};
`else
    assign ds_hit_c = ~uds_q;
    assign be_c     = 2'b11;
`endif

    assign hit_c    = ~as_q & ~rw_q & (A[23:20] == ADDR_HI) & ds_hit_c;
    // Full FIFO still has room when the head is being popped this edge.
    assign space_c  = ~full_w | out_ack;
    assign wentry_c = pack_entry(A, D, be_c);

    // Push strobe: one per bus cycle, from IDLE on a hit or from STALL once room appears.
    always_comb begin
        push_c = 1'b0;
        case (state_q)
            ST_IDLE:  push_c = hit_c & space_c;
            ST_STALL: push_c = ~as_q & space_c;
            default:  push_c = 1'b0;
        endcase
    end

    // Bus FSM and registered DTACK enable.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            dtack_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hit_c) begin
                        if (space_c) begin
                            state_q <= ST_ACK;
                            dtack_q <= 1'b1;
                        end else begin
                            state_q <= ST_STALL;
                        end
                    end
                end
                ST_STALL: begin
                    if (as_q) begin
                        state_q <= ST_IDLE;
                    end else if (space_c) begin
                        state_q <= ST_ACK;
                        dtack_q <= 1'b1;
                    end
                end
                ST_ACK: begin
                    if (uds_q && lds_q) begin
                        state_q <= ST_DONE;
                        dtack_q <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (as_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    dtack_q <= 1'b0;
                end
            endcase
        end
    end

    picovid_wbuf_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .push_i  (push_c),
        .pop_i   (out_ack),
        .wdata_i (wentry_c),
        .rdata_o (head_w),
        .fill_o  (fill),
        .full_o  (full_w),
        .empty_o (empty_w)
    );

    // Open-drain DTACK: pull low while acking, float otherwise.
    assign DTACK     = dtack_q ? 1'b0 : 1'bz;

    assign out_valid = ~empty_w;
    assign out_addr  = head_w[ADDR_LSB +: ADDR_W];
    assign out_data  = head_w[DATA_LSB +: DATA_W];
    assign out_be    = head_w[BE_LSB +: BE_W];

endmodule

// File: tb/tb_picovid_wbuf.sv
// Self-checking bench for picovid_wbuf: queue-based reference model plus directed cases.
module tb_picovid_wbuf;

    localparam int unsigned DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        AS = 1'b1, UDS = 1'b1, LDS = 1'b1, RW = 1'b1;
    logic [23:1] A = '0;
    logic [15:0] D = '0;
    logic        out_ack = 1'b0;
    wire         dtack_w;
    logic        out_valid;
    logic [23:0] out_addr;
    logic [15:0] out_data;
    logic [1:0]  out_be;
    logic [2:0]  fill;

    pullup (dtack_w);

    picovid_wbuf #(.ADDR_HI(4'hD), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET(RESET), .AS(AS), .UDS(UDS), .LDS(LDS), .RW(RW),
        .A(A), .D(D), .DTACK(dtack_w), .out_valid(out_valid),
        .out_addr(out_addr), .out_data(out_data), .out_be(out_be),
        .out_ack(out_ack), .fill(fill)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a write bus cycle is accepted once, one clock after its
    // strobes are visible, whenever the queue has room (or is popped that edge).
    typedef struct { logic [23:0] a; logic [15:0] d; logic [1:0] be; } ent_t;
    ent_t q[$];
    logic m_as = 1'b1, m_uds = 1'b1, m_lds = 1'b1, m_rw = 1'b1;
    bit   m_taken = 1'b0;
    bit   m_dt = 1'b0;
    bit   m_hit, m_pop, m_push;
    ent_t m_e;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            q.delete();
            m_as = 1'b1; m_uds = 1'b1; m_lds = 1'b1; m_rw = 1'b1;
            m_taken = 1'b0;
            m_dt = 1'b0;
        end else begin
`ifdef PICOVID_WBUF_BYTELANE_EN
            m_hit = !m_as && !m_rw && (A[23:20] == 4'hD) && (!m_uds || !m_lds);
            m_e.be = {!m_uds, !m_lds};
`else
            m_hit = !m_as && !m_rw && (A[23:20] == 4'hD) && !m_uds;
            m_e.be = 2'b11;
`endif
            m_pop  = out_ack && (q.size() > 0);
            m_push = m_hit && !m_taken && ((q.size() < int'(DEPTH)) || m_pop);
            if (m_dt) begin
                if (m_uds && m_lds) m_dt = 1'b0;
            end else if (m_push) begin
                m_dt = 1'b1;
            end
            if (m_as) m_taken = 1'b0;
            else if (m_push) m_taken = 1'b1;
            if (m_pop) void'(q.pop_front());
            if (m_push) begin
                m_e.a = {A, 1'b0};
                m_e.d = D;
                q.push_back(m_e);
            end
            m_as = AS; m_uds = UDS; m_lds = LDS; m_rw = RW;
        end
    end

    // Every-cycle comparison against the model, sampled on the falling edge.
    always @(negedge CLK) begin
        chk("m_dtack", 32'(dtack_w), 32'(!m_dt));
        chk("m_fill", 32'(fill), 32'(q.size()));
        chk("m_valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("m_addr", 32'(out_addr), 32'(q[0].a));
            chk("m_data", 32'(out_data), 32'(q[0].d));
            chk("m_be", 32'(out_be), 32'(q[0].be));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_write(input logic [23:0] addr, input logic [15:0] data,
                               input logic u, input logic l);
        A = addr[23:1]; D = data; RW = 1'b0; AS = 1'b0; UDS = u; LDS = l;
    endtask

    task automatic end_cycle();
        AS = 1'b1; UDS = 1'b1; LDS = 1'b1; RW = 1'b1;
    endtask

    task automatic do_write(input logic [23:0] addr, input logic [15:0] data);
        bit got = 1'b0;
        start_write(addr, data, 1'b0, 1'b0);
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (dtack_w == 1'b0) got = 1'b1;
        end
        chk("write_ack", 32'(got), 32'd1);
        end_cycle();
        repeat (3) tick();
    endtask

    task automatic pop_expect(input logic [15:0] data);
        chk("pop_head", 32'(out_data), 32'(data));
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        #12 RESET = 1'b1;
        tick();
        chk("rst_dtack", 32'(dtack_w), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_fill", 32'(fill), 32'd0);
        chk("rst_addr", 32'(out_addr), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_be", 32'(out_be), 32'd0);

        // Single word write: DTACK two cycles after the strobes.
        start_write(24'hD01234, 16'hBEEF, 1'b0, 1'b0);
        tick();
        chk("t1_dtack_early", 32'(dtack_w), 32'd1);
        tick();
        chk("t1_dtack", 32'(dtack_w), 32'd0);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_addr", 32'(out_addr), 32'hD01234);
        chk("t1_data", 32'(out_data), 32'hBEEF);
        chk("t1_be", 32'(out_be), 32'd3);
        chk("t1_fill", 32'(fill), 32'd1);
        end_cycle();
        tick();
        chk("t1_dtack_hold", 32'(dtack_w), 32'd0);
        tick();
        chk("t1_dtack_rel", 32'(dtack_w), 32'd1);
        tick();
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        chk("t1_fill_pop", 32'(fill), 32'd0);
        chk("t1_valid_pop", 32'(out_valid), 32'd0);

        // Out-of-window write and in-window read are ignored.
        start_write(24'hC00000, 16'h1111, 1'b0, 1'b0);
        repeat (4) tick();
        chk("t2_nowin_dtack", 32'(dtack_w), 32'd1);
        chk("t2_nowin_fill", 32'(fill), 32'd0);
        end_cycle();
        repeat (2) tick();
        A = 23'h680000; RW = 1'b1; AS = 1'b0; UDS = 1'b0; LDS = 1'b0;
        repeat (4) tick();
        chk("t2_read_dtack", 32'(dtack_w), 32'd1);
        chk("t2_read_fill", 32'(fill), 32'd0);
        end_cycle();
        repeat (2) tick();

        // Fill to DEPTH, stall a fifth write, release it with a pop, drain across wrap.
        for (int i = 0; i < 4; i++) do_write(24'hD00100 + 24'(2 * i), 16'h1000 + 16'(i));
        chk("t3_full", 32'(fill), 32'd4);
        start_write(24'hD00200, 16'h2004, 1'b0, 1'b0);
        repeat (4) tick();
        chk("t3_stall_dtack", 32'(dtack_w), 32'd1);
        chk("t3_stall_fill", 32'(fill), 32'd4);
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        chk("t3_push_fill", 32'(fill), 32'd4);
        chk("t3_push_dtack", 32'(dtack_w), 32'd0);
        chk("t3_head", 32'(out_data), 32'h1001);
        end_cycle();
        repeat (3) tick();
        pop_expect(16'h1001);
        pop_expect(16'h1002);
        pop_expect(16'h1003);
        chk("t3_wrap_addr", 32'(out_addr), 32'hD00200);
        pop_expect(16'h2004);
        chk("t3_empty", 32'(fill), 32'd0);

        // Push and pop on the same edge at fill=2.
        do_write(24'hD00300, 16'h3000);
        do_write(24'hD00302, 16'h3001);
        start_write(24'hD00304, 16'h3002, 1'b0, 1'b0);
        tick();
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        chk("t4_fill", 32'(fill), 32'd2);
        chk("t4_head", 32'(out_data), 32'h3001);
        end_cycle();
        repeat (3) tick();
        pop_expect(16'h3001);
        pop_expect(16'h3002);

        // Lower-byte-only write.
        start_write(24'hD00010, 16'h00A5, 1'b1, 1'b0);
        repeat (4) tick();
`ifdef PICOVID_WBUF_BYTELANE_EN
        chk("t5_dtack", 32'(dtack_w), 32'd0);
        chk("t5_be", 32'(out_be), 32'd1);
        chk("t5_fill", 32'(fill), 32'd1);
        end_cycle();
        repeat (3) tick();
        pop_expect(16'h00A5);
`else
        chk("t5_dtack", 32'(dtack_w), 32'd1);
        chk("t5_fill", 32'(fill), 32'd0);
        end_cycle();
        repeat (3) tick();
`endif

        // Asynchronous reset while acking with three entries queued.
        do_write(24'hD00400, 16'h4000);
        do_write(24'hD00402, 16'h4001);
        start_write(24'hD00404, 16'h4002, 1'b0, 1'b0);
        tick();
        tick();
        chk("t6_pre_dtack", 32'(dtack_w), 32'd0);
        chk("t6_pre_fill", 32'(fill), 32'd3);
        #1 RESET = 1'b0;
        #1;
        chk("t6_rst_dtack", 32'(dtack_w), 32'd1);
        chk("t6_rst_fill", 32'(fill), 32'd0);
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        end_cycle();
        @(negedge CLK);
        #2 RESET = 1'b1;
        tick();
        chk("t6_post_fill", 32'(fill), 32'd0);
        chk("t6_post_dtack", 32'(dtack_w), 32'd1);
        do_write(24'hD00500, 16'h5A5A);
        chk("t6_next_fill", 32'(fill), 32'd1);
        chk("t6_next_data", 32'(out_data), 32'h5A5A);
        pop_expect(16'h5A5A);
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
